// File: rtl/vc_fifo_bank_pkg.sv
// Shared helpers for the virtual-channel FIFO bank: width math for channel indices.
package vc_fifo_pkg;

  // Ceiling log2 for elaboration-time sizing; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Channel index width, never narrower than one bit so a single-VC bank still has a select.
  function automatic int vc_width(input int num_vc);
    return (clog2(num_vc) < 1) ? 1 : clog2(num_vc);
  endfunction

endpackage

// File: rtl/vc_fifo_bank_if.sv
// Write/read request bus, thresholds and status outputs of the VC FIFO bank.
interface vc_fifo_bank_if import vc_fifo_pkg::*; #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_VC     = 2
) ();
  localparam int VC_W = vc_width(NUM_VC);
  localparam int TW   = ADDR_WIDTH + 1;

  logic                         wr_enable;
  logic [VC_W-1:0]              wr_vc;
  logic [DATA_WIDTH-1:0]        data_in;
  logic                         rd_enable;
  logic [VC_W-1:0]              rd_vc;
  logic [NUM_VC*TW-1:0]         umbral_af;
  logic [NUM_VC*TW-1:0]         umbral_ae;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         data_out_valid;
  logic [NUM_VC*DATA_WIDTH-1:0] data_head;
  logic [NUM_VC-1:0]            full;
  logic [NUM_VC-1:0]            empty;
  logic [NUM_VC-1:0]            almost_full;
  logic [NUM_VC-1:0]            almost_empty;
  logic [NUM_VC-1:0]            error;

  modport master (
    output wr_enable, wr_vc, data_in, rd_enable, rd_vc, umbral_af, umbral_ae,
    input  data_out, data_out_valid, data_head, full, empty, almost_full, almost_empty, error
  );

  modport slave (
    input  wr_enable, wr_vc, data_in, rd_enable, rd_vc, umbral_af, umbral_ae,
    output data_out, data_out_valid, data_head, full, empty, almost_full, almost_empty, error
  );
endinterface

// File: rtl/vc_fifo_bank_channel.sv
// One virtual-channel FIFO: storage, wrapping pointers, occupancy count, status flags and head view.
// Acceptance decisions are made by the bank; this block just applies them.
module vc_fifo_channel import vc_fifo_pkg::*; #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH:0]   af_thr_i,
  input  logic [ADDR_WIDTH:0]   ae_thr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Advance pointers on accepted operations; a simultaneous read and write leaves the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_i) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_i) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({wr_i, rd_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers; reset drops every stored entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array is never cleared; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (wr_i) mem[wr_ptr_q] <= data_i;
  end

  assign rd_data_o      = mem[rd_ptr_q];
  assign head_o         = empty_o ? '0 : mem[rd_ptr_q];
  assign full_o         = (cnt_q == CW'(DEPTH));
  assign empty_o        = (cnt_q == '0);
  assign almost_full_o  = (cnt_q >= af_thr_i);
  assign almost_empty_o = (cnt_q <= ae_thr_i);
endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC FIFOs behind a shared write port and read port. Decodes the channel
// selects, decides acceptance, muxes read data into a registered output and keeps sticky errors.
module vc_fifo_bank import vc_fifo_pkg::*; #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_VC     = 2
) (
  input logic          clk,
  input logic          reset,
  vc_fifo_bank_if.slave bus
);
  localparam int TW = ADDR_WIDTH + 1;

  logic [NUM_VC-1:0]     wr_sel, rd_sel;
  logic [NUM_VC-1:0]     full_w, empty_w, af_w, ae_w;
  logic [DATA_WIDTH-1:0] rd_data_w [NUM_VC];
  logic [NUM_VC*DATA_WIDTH-1:0] head_w;
  logic                  wr_vc_ok, rd_vc_ok, wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_out_valid_q;
  logic [NUM_VC-1:0]     error_q, error_d;

  // Acceptance: a full channel still takes a write when the same cycle reads from it.
  always_comb begin
    wr_vc_ok = (int'(bus.wr_vc) < NUM_VC);
    rd_vc_ok = (int'(bus.rd_vc) < NUM_VC);
    rd_acc   = bus.rd_enable && rd_vc_ok && !empty_w[bus.rd_vc];
    wr_acc   = bus.wr_enable && wr_vc_ok &&
               (!full_w[bus.wr_vc] || (rd_acc && (bus.rd_vc == bus.wr_vc)));
    wr_sel   = '0;
    rd_sel   = '0;
    if (wr_acc) wr_sel[bus.wr_vc] = 1'b1;
    if (rd_acc) rd_sel[bus.rd_vc] = 1'b1;
  end

  for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
    vc_fifo_channel #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_channel (
      .clk           (clk),
      .reset         (reset),
      .wr_i          (wr_sel[k]),
      .rd_i          (rd_sel[k]),
      .data_i        (bus.data_in),
      .af_thr_i      (bus.umbral_af[k*TW +: TW]),
      .ae_thr_i      (bus.umbral_ae[k*TW +: TW]),
      .rd_data_o     (rd_data_w[k]),
      .head_o        (head_w[k*DATA_WIDTH +: DATA_WIDTH]),
      .full_o        (full_w[k]),
      .empty_o       (empty_w[k]),
      .almost_full_o (af_w[k]),
      .almost_empty_o(ae_w[k])
    );
  end

  // Registered read data: valid pulses for one cycle per accepted read, data holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
    end else begin
      data_out_valid_q <= rd_acc;
      if (rd_acc) data_out_q <= rd_data_w[bus.rd_vc];
    end
  end

  // Rejected requests mark their channel; bits only ever get set until reset.
  always_comb begin
    error_d = error_q;
    if (bus.wr_enable && wr_vc_ok && !wr_acc) error_d[bus.wr_vc] = 1'b1;
    if (bus.rd_enable && rd_vc_ok && !rd_acc) error_d[bus.rd_vc] = 1'b1;
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (reset) error_q <= '0;
    else       error_q <= error_d;
  end

  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.data_head      = head_w;
  assign bus.full           = full_w;
  assign bus.empty          = empty_w;
  assign bus.almost_full    = af_w;
  assign bus.almost_empty   = ae_w;
  assign bus.error          = error_q;
endmodule
